// File: rtl/aux_packet_tx.sv
// Test-traffic transmitter: bursts of fixed-length packets carrying an aux
// sequence byte, with optional suppression of one packet per run.
module aux_packet_tx #(
   parameter int         PACKETSIZE  = 33,
   parameter int         WHEREIS_AUX = 0,
   parameter int         GAP         = 10,
   parameter logic [7:0] FILL        = 8'h12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] segment_number_max,
   input  logic [7:0]  aux_count,
   input  logic        drop_en,
   input  logic [7:0]  drop_aux,
   input  logic [15:0] drop_seg,
   output logic        tx_en,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        done,
   output logic [7:0]  aux_out,
   output logic [15:0] seg_out,
   output logic [31:0] sent_count
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [15:0] LAST_IDX = 16'(PACKETSIZE - 1);
   localparam logic [15:0] AUX_IDX  = 16'(WHEREIS_AUX);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP,
      S_FIN
   } state_t;

   state_t state_q, state_d;

   logic [15:0]   seg_max_q, seg_max_d;
   logic [7:0]    aux_cnt_q, aux_cnt_d;
   logic          drop_en_q, drop_en_d;
   logic [7:0]    drop_aux_q, drop_aux_d;
   logic [15:0]   drop_seg_q, drop_seg_d;
   logic [15:0]   idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    aux_q, aux_d;
   logic [15:0]   seg_q, seg_d;
   logic [31:0]   sent_q, sent_d;
   logic          tx_en_q, tx_en_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic drop_hit;
   logic seg_last;
   logic aux_last;

   assign drop_hit = drop_en_q && (aux_q == drop_aux_q)
                     && (seg_q == drop_seg_q);
   assign seg_last = (seg_q == seg_max_q - 16'd1);
   // aux_count of 0 means 256 values, so the last aux is 255
   assign aux_last = (aux_q == aux_cnt_q - 8'd1);

   always_comb begin
      state_d    = state_q;
      seg_max_d  = seg_max_q;
      aux_cnt_d  = aux_cnt_q;
      drop_en_d  = drop_en_q;
      drop_aux_d = drop_aux_q;
      drop_seg_d = drop_seg_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      aux_d      = aux_q;
      seg_d      = seg_q;
      sent_d     = sent_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               seg_max_d  = segment_number_max;
               aux_cnt_d  = aux_count;
               drop_en_d  = drop_en;
               drop_aux_d = drop_aux;
               drop_seg_d = drop_seg;
               if (segment_number_max == 16'd0) begin
                  state_d = S_FIN;
               end else begin
                  aux_d   = 8'd0;
                  seg_d   = 16'd0;
                  idx_d   = 16'd0;
                  state_d = S_SEND;
               end
            end
         end
         S_SEND: begin
            idx_d = idx_q + 16'd1;
            if (idx_q == LAST_IDX) begin
               gap_d   = '0;
               state_d = S_GAP;
               if (!drop_hit) sent_d = sent_q + 32'd1;
            end
         end
         S_GAP: begin
            gap_d = gap_q + GW'(1);
            if (gap_q == GAP_LAST) begin
               if (seg_last) begin
                  seg_d = 16'd0;
                  aux_d = aux_q + 8'd1;
               end else begin
                  seg_d = seg_q + 16'd1;
               end
               if (seg_last && aux_last) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = 16'd0;
                  state_d = S_SEND;
               end
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Byte outputs are registered from the current state, one cycle behind it
   always_comb begin
      tx_en_d   = (state_q == S_SEND) && !drop_hit;
      tx_data_d = 8'h00;
      if (tx_en_d) tx_data_d = (idx_q == AUX_IDX) ? aux_q : FILL;
      busy_d = (state_q != S_IDLE);
      done_d = (state_q == S_FIN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         seg_max_q  <= '0;
         aux_cnt_q  <= '0;
         drop_en_q  <= 1'b0;
         drop_aux_q <= '0;
         drop_seg_q <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         aux_q      <= '0;
         seg_q      <= '0;
         sent_q     <= '0;
         tx_en_q    <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seg_max_q  <= seg_max_d;
         aux_cnt_q  <= aux_cnt_d;
         drop_en_q  <= drop_en_d;
         drop_aux_q <= drop_aux_d;
         drop_seg_q <= drop_seg_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         aux_q      <= aux_d;
         seg_q      <= seg_d;
         sent_q     <= sent_d;
         tx_en_q    <= tx_en_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_en      = tx_en_q;
   assign tx_data    = tx_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aux_out    = aux_q;
   assign seg_out    = seg_q;
   assign sent_count = sent_q;

endmodule

// File: tb/tb_aux_packet_tx.sv
// Bench for aux_packet_tx: table-driven and random runs compared
// cycle by cycle against a per-packet stream model.
module tb_aux_packet_tx;

   localparam int P  = 33;
   localparam int WA = 0;
   localparam int G  = 10;
   localparam logic [7:0] FILL = 8'h12;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] segment_number_max = '0;
   logic [7:0]  aux_count = '0;
   logic        drop_en = 1'b0;
   logic [7:0]  drop_aux = '0;
   logic [15:0] drop_seg = '0;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        busy;
   logic        done;
   logic [7:0]  aux_out;
   logic [15:0] seg_out;
   logic [31:0] sent_count;

   int passed = 0;
   int total  = 0;

   always #4 clk = ~clk;

   aux_packet_tx #(
      .PACKETSIZE(P), .WHEREIS_AUX(WA), .GAP(G), .FILL(FILL)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .segment_number_max(segment_number_max),
      .aux_count(aux_count), .drop_en(drop_en),
      .drop_aux(drop_aux), .drop_seg(drop_seg),
      .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .done(done),
      .aux_out(aux_out), .seg_out(seg_out), .sent_count(sent_count)
   );

   typedef struct {
      logic [15:0] seg;
      logic [7:0]  cnt;
      logic        de;
      logic [7:0]  da;
      logic [15:0] ds;
      int          mid;
      int          exp_sent;
   } vec_t;

   // {done, tx_en, tx_data} per visible cycle
   logic [9:0] exp_q[$];

   task automatic check(input string name, input logic ok,
                        input longint got, input longint want);
      total++;
      if (ok) passed++;
      else $display("FAIL %s got=%0h want=%0h", name, got, want);
   endtask

   function automatic int build(input int seg, input int cnt,
                                input bit de, input int da, input int ds);
      int n;
      int pk;
      bit dr;
      exp_q.delete();
      pk = 0;
      n = (cnt == 0) ? 256 : cnt;
      if (seg != 0) begin
         for (int a = 0; a < n; a++) begin
            for (int s = 0; s < seg; s++) begin
               dr = de && (a == da) && (s == ds);
               if (!dr) pk++;
               for (int i = 0; i < P; i++) begin
                  if (dr) exp_q.push_back(10'h000);
                  else if (i == WA) exp_q.push_back({2'b01, 8'(a)});
                  else exp_q.push_back({2'b01, FILL});
               end
               for (int i = 0; i < G; i++) exp_q.push_back(10'h000);
            end
         end
      end
      exp_q.push_back(10'h200);
      return pk;
   endfunction

   task automatic run(input vec_t v, input string tag);
      int model_pk;
      int bad;
      logic [9:0] got;
      logic [9:0] first_got;
      logic [9:0] first_want;
      int first_i;
      logic [31:0] sent0;
      model_pk = build(v.seg, v.cnt, v.de, v.da, v.ds);
      if (v.exp_sent >= 0)
         check({tag, "_model_pk"}, model_pk == v.exp_sent,
               model_pk, v.exp_sent);
      sent0 = sent_count;
      @(negedge clk);
      segment_number_max = v.seg;
      aux_count = v.cnt;
      drop_en = v.de;
      drop_aux = v.da;
      drop_seg = v.ds;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_latency"}, !tx_en && !busy, {busy, tx_en}, 0);
      @(posedge clk);
      #1;
      bad = 0;
      first_i = 0;
      first_got = '0;
      first_want = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = {done, tx_en, tx_data};
         if (got !== exp_q[i] || busy !== 1'b1) begin
            if (bad == 0) begin
               first_i = i;
               first_got = got;
               first_want = exp_q[i];
            end
            bad++;
         end
         start = (i == v.mid);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      if (bad != 0)
         $display("FAIL %s_stream cycle %0d got=%0h want=%0h",
                  tag, first_i, first_got, first_want);
      total++;
      if (bad == 0) passed++;
      check({tag, "_idle"}, !busy && !tx_en && !done,
            {busy, tx_en, done}, 0);
      check({tag, "_sent"}, sent_count - sent0 == 32'(model_pk),
            sent_count - sent0, model_pk);
      if (v.seg != 0)
         check({tag, "_auxseg"},
               aux_out == v.cnt && seg_out == 16'd0,
               {aux_out, seg_out}, {v.cnt, 16'd0});
   endtask

   vec_t tbl[6];
   vec_t rv;

   initial begin
      tbl[0] = '{16'd2, 8'd2, 1'b0, 8'd0, 16'd0, -1, 4};
      tbl[1] = '{16'd16, 8'd13, 1'b1, 8'd12, 16'd7, -1, 207};
      tbl[2] = '{16'd0, 8'd5, 1'b0, 8'd0, 16'd0, -1, 0};
      tbl[3] = '{16'd1, 8'd0, 1'b0, 8'd0, 16'd0, -1, 256};
      tbl[4] = '{16'd3, 8'd2, 1'b1, 8'd1, 16'd2, 60, 5};
      tbl[5] = '{16'd2, 8'd1, 1'b1, 8'd5, 16'd0, 20, 2};

      repeat (3) @(posedge clk);
      #1;
      check("reset_outs",
            !tx_en && tx_data == 0 && !busy && !done
            && aux_out == 0 && seg_out == 0 && sent_count == 0,
            {tx_en, tx_data, busy, done, aux_out, seg_out}, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 6; k++) run(tbl[k], $sformatf("vec%0d", k));

      for (int k = 0; k < 4; k++) begin
         rv.seg = 16'($urandom_range(1, 3));
         rv.cnt = 8'($urandom_range(1, 4));
         rv.de  = 1'($urandom_range(0, 1));
         rv.da  = 8'($urandom_range(0, 4));
         rv.ds  = 16'($urandom_range(0, 3));
         rv.mid = int'($urandom_range(0, 80));
         rv.exp_sent = -1;
         run(rv, $sformatf("rnd%0d", k));
      end

      // reset in the middle of a packet
      @(negedge clk);
      segment_number_max = 16'd1;
      aux_count = 8'd1;
      drop_en = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mid_pkt_active", tx_en, tx_en, 1);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", !tx_en && !busy && sent_count == 0,
            {tx_en, busy, sent_count}, 0);
      @(negedge clk);
      rst = 1'b1;
      rv = '{16'd1, 8'd1, 1'b0, 8'd0, 16'd0, -1, 1};
      run(rv, "post_reset");
      check("post_reset_sent", sent_count == 32'd1, sent_count, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
